// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift engine.
// Latency: none (declarations only).
// Backpressure: not applicable.
package shift_pkg;

  // Operation encodings carried on in_op. 3'b111 is treated like PASS.
  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_SLA  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_PASS = 3'b110
  } shift_op_e;

  // Controller state encoding.
  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] BUSY_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_BUSY = BUSY_ENC,
    ST_DONE = DONE_ENC
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 0..STEP positions for one op.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   data     - word to shift
//   op       - shift_op_e encoding
//   amt      - positions to move this step (0..STEP)
//   sign     - fill/reference bit: original sign for SRA/SLA, 0 for SLL
//   result   - shifted word
//   mismatch - for left shifts, some bit pushed out of the MSB differed from sign
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sign,
  output logic [WIDTH-1:0] result,
  output logic             mismatch
);

  // Unrolled chain of STEP single-bit stages; stage i is active when i < amt.
  always_comb begin
    result   = data;
    mismatch = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amt)) begin
        case (op)
          OP_SLL, OP_SLA: begin
            // With sign=0 this flags any 1 lost from an SLL; with the
            // original sign it flags an SLA bit that breaks representability.
            mismatch = mismatch | (result[WIDTH-1] ^ sign);
            result   = {result[WIDTH-2:0], 1'b0};
          end
          OP_SRL:  result = {1'b0, result[WIDTH-1:1]};
          OP_SRA:  result = {sign, result[WIDTH-1:1]};
          OP_ROL:  result = {result[WIDTH-2:0], result[WIDTH-1]};
          OP_ROR:  result = {result[0], result[WIDTH-1:1]};
          default: result = result;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift engine (SLL/SRL/SRA/SLA/ROL/ROR/PASS) with overflow flag.
// Latency: result valid ceil(eff/STEP)+1 cycles after the request transfer.
// Backpressure: in_ready low while BUSY/DONE; result held until out_ready.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - request handshake; in_op, in_data, in_shamt payload
//   out_valid/out_ready  - result handshake; out_data, out_ovf payload
// Build option: define SHIFT_SAT_EN to saturate overflowing SLA results to the
// signed limit matching the operand sign.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf
);

  localparam int AMT_W = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(STEP);

`ifdef SHIFT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] rem_q;
  logic               sign_q;
  logic               ovf_q;

  logic [SHAMT_W-1:0] eff;
  logic [SHAMT_W-1:0] step_n;
  logic               step_sign;
  logic [WIDTH-1:0]   step_res;
  logic               step_mm;
  logic               ovf_acc;
  logic               fin_ovf;
  logic [WIDTH-1:0]   fin_data;

  // Effective amount: shifts clamp at WIDTH (all bits gone), rotates wrap.
  always_comb begin
    eff = '0;
    case (in_op)
      OP_SLL, OP_SRL, OP_SRA, OP_SLA: eff = (in_shamt > WIDTH_C) ? WIDTH_C : in_shamt;
      OP_ROL, OP_ROR:                 eff = in_shamt % WIDTH_C;
      default:                        eff = '0;
    endcase
  end

  assign step_n    = (rem_q > STEP_C) ? STEP_C : rem_q;
  // SLL compares shifted-out bits against 0, SLA/SRA use the original sign.
  assign step_sign = (op_q == OP_SLL) ? 1'b0 : sign_q;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .data     (work_q),
    .op       (op_q),
    .amt      (AMT_W'(step_n)),
    .sign     (step_sign),
    .result   (step_res),
    .mismatch (step_mm)
  );

  // Result of the last BUSY step, including the SLA final-MSB check.
  always_comb begin
    ovf_acc  = ovf_q | step_mm;
    fin_ovf  = 1'b0;
    fin_data = step_res;
    case (op_q)
      OP_SLL:  fin_ovf = ovf_acc;
      OP_SLA:  fin_ovf = ovf_acc | (step_res[WIDTH-1] ^ sign_q);
      default: fin_ovf = 1'b0;
    endcase
    if (SAT_EN && (op_q == OP_SLA) && fin_ovf) begin
      fin_data = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_PASS;
      work_q    <= '0;
      rem_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            work_q   <= in_data;
            sign_q   <= in_data[WIDTH-1];
            rem_q    <= eff;
            ovf_q    <= 1'b0;
            in_ready <= 1'b0;
            if (eff == '0) begin
              // Nothing to move: operand is the result and cannot overflow.
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_ovf   <= 1'b0;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          work_q <= step_res;
          ovf_q  <= ovf_acc;
          rem_q  <= rem_q - step_n;
          if (rem_q == step_n) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= fin_data;
            out_ovf   <= fin_ovf;
          end
        end
        ST_DONE: begin
          // in_ready rises only after the result leaves, so a new request
          // is never accepted on the output handshake edge.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Parametrised, multi-cycle shift engine.
- Generalises the fixed 4-bit logical/arithmetic shift check in four ways: configurable data width, configurable bits shifted per cycle, six shift modes including rotates, and an overflow flag.
- Sits between a requester and a consumer, with valid/ready handshakes on both sides.
- Serves as the reusable shifter for the team's datapath experiments and verilator benches.

Parameters:
- WIDTH, 8, data width in bits (≥2).
- STEP, 1, maximum bit positions shifted per BUSY cycle (1..WIDTH).
- SHAMT_W, $clog2(WIDTH)+1, shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 SLA, 100 ROL, 101 ROR, 110/111 PASS.
- in_data  in  WIDTH  operand (SRA/SLA treat it as two's-complement signed).
- in_shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_ovf  out  1  overflow: SLL shifted out a 1, or SLA result not representable.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - State returns to IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_ovf=0.
  - Any in-flight request is discarded, including a reset asserted in BUSY or DONE.
- States: IDLE → (BUSY | DONE) → IDLE.
- IDLE:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready. On that edge, latch op, data and the effective amount eff.
  - If eff=0 (or op is PASS), go to DONE; otherwise go to BUSY.
- Effective amount eff:
  - Shifts: min(in_shamt, WIDTH).
  - Rotates: in_shamt mod WIDTH.
  - PASS: 0.
- BUSY:
  - in_ready=0.
  - Each edge applies s=min(STEP, remaining) positions to the working register and decrements remaining by s.
  - When remaining reaches 0, go to DONE.
- Fill rules:
  - SLL/SLA fill zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA replicates the original sign bit.
  - Rotates wrap bits around.
  - SLL/SRL by WIDTH give 0. SRA by WIDTH gives all sign bits.
- Latency: with the transfer in cycle k, out_valid=1 in cycle k+1+ceil(eff/STEP).
- out_ovf:
  - SLL: 1 if any bit shifted out is 1 (accumulated sticky over the BUSY steps).
  - SLA: 1 if any bit shifted out, or the final MSB, differs from the original sign bit.
  - All other ops: 0.
- DONE:
  - out_valid=1; out_data and out_ovf are held stable until out_valid & out_ready.
  - On that edge, go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE, so no new request is accepted in the same cycle as the result handshake. Throughput is one request per (latency+1) cycles.
- Input stability: changes on in_* while in_ready=0 are ignored.
- Outputs: registered; no combinational path from in_* to out_*.

Optional Feature:
- Macro: SHIFT_SAT_EN.
- Defined: when an SLA has out_ovf=1, out_data saturates to the signed limit matching the original sign. Positive operands give 0 followed by ones (0111…); negative operands give 1 followed by zeros (1000…). out_ovf is still 1. All other ops are unchanged.
- Undefined: SLA out_data equals SLL out_data, i.e. wrapped bits.

Decomposition:
- Package shift_pkg holds:
  - the op encodings as typedef enum logic [2:0] shift_op_e;
  - localparams for the state encoding (IDLE, BUSY, DONE).
- Natural sub-module: shift_step. It is a combinational single-step shifter: inputs are data, op, amount (0..STEP) and original sign; outputs are shifted data and a shifted-out-mismatch bit.
- shift_unit holds the FSM, the remaining counter, the working register and the sticky overflow flag.

Test Plan (WIDTH=4, STEP=1 unless stated):
- SRA, 4'b1001, shamt=2 → out_data=4'b1110, out_ovf=0, out_valid in cycle k+3.
- SLL, 4'b1011, shamt=2 → out_data=4'b1100, out_ovf=1. Then SRL, 4'b1011, shamt=5 → eff clamped to 4, out_data=4'b0000.
- SLA, 4'b0101, shamt=1 → 4'b1010, out_ovf=1. With SHIFT_SAT_EN → 4'b0111, out_ovf=1. SLA, 4'b1110, shamt=1 → 4'b1100, out_ovf=0.
- ROR, 4'b0001, shamt=1 → 4'b1000. ROL, 4'b0011, shamt=5 → eff=1 → 4'b0110. ROL with shamt=4 → eff=0 → out_valid in cycle k+1.
- WIDTH=8, STEP=3: SRL, 8'hF0, shamt=7 → 8'h01, out_valid at k+1+3=k+4. Hold out_ready=0 for 5 cycles → out_data stable and in_ready=0 throughout.
- Assert rst_n=0 for one cycle while in BUSY → next cycle IDLE, in_ready=1, out_valid=0. A fresh request then completes with correct data.
